// File: rtl/lsu_ctrl_if.sv
// Load/store unit bus bundle: MEM-stage request/response plus data-memory port.
interface lsu_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   // Pipeline request
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   // Pipeline response
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_fault;
   // Data memory port
   logic              dm_we;
   logic [ADDR_W-1:0] dm_A;
   logic [31:0]       dm_WD;
   logic [31:0]       dm_RD;

   // Pipeline and memory side (drives requests, provides read data)
   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_RD,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault, dm_we, dm_A, dm_WD
   );

   // Load/store unit side
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dm_RD,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault, dm_we, dm_A, dm_WD
   );
endinterface

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store control: turns byte/half/word requests into word-only
// memory accesses (RMW for sub-word stores, lane extract + extend for loads).
module lsu_ctrl #(
   parameter int unsigned DM_WORDS = 64,
   parameter int unsigned ADDR_W   = 32
) (
   input logic         clk,
   input logic         rst_n,
   lsu_ctrl_if.slave   bus
);
   localparam int unsigned IDX_W = ADDR_W - 2;
   localparam logic [IDX_W-1:0] DM_LIMIT = IDX_W'(DM_WORDS);
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       merge_q, merge_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              fault_q, fault_d;

   logic        ready_c;
   logic        accept_c;
   logic        fault_c;
   logic [4:0]  bsh_c;
   logic [4:0]  hsh_c;
   logic [7:0]  lane_b_c;
   logic [15:0] lane_h_c;
   logic [31:0] ld_data_c;
   logic [31:0] st_merge_c;

   assign ready_c  = (state_q == IDLE) || (state_q == RESP);
   assign accept_c = bus.req_valid && ready_c;

   // Reject illegal size, misalignment, or a word index beyond the memory
   always_comb begin
      fault_c = 1'b0;
      if (bus.req_size == SZ_X) fault_c = 1'b1;
      if ((bus.req_size == SZ_H) && bus.req_addr[0]) fault_c = 1'b1;
      if ((bus.req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00)) fault_c = 1'b1;
      if (bus.req_addr[ADDR_W-1:2] >= DM_LIMIT) fault_c = 1'b1;
   end

   // Little-endian lane extraction, extension and sub-word merge
   always_comb begin
      bsh_c    = {addr_q[1:0], 3'b000};
      hsh_c    = {addr_q[1], 4'b0000};
      lane_b_c = 8'(bus.dm_RD >> bsh_c);
      lane_h_c = addr_q[1] ? bus.dm_RD[31:16] : bus.dm_RD[15:0];
      case (size_q)
         SZ_B:    ld_data_c = {{24{~uns_q & lane_b_c[7]}}, lane_b_c};
         SZ_H:    ld_data_c = {{16{~uns_q & lane_h_c[15]}}, lane_h_c};
         default: ld_data_c = bus.dm_RD;
      endcase
      if (size_q == SZ_H)
         st_merge_c = (bus.dm_RD & ~(32'h0000_FFFF << hsh_c)) |
                      ({16'h0000, wdata_q[15:0]} << hsh_c);
      else
         st_merge_c = (bus.dm_RD & ~(32'h0000_00FF << bsh_c)) |
                      ({24'h00_0000, wdata_q[7:0]} << bsh_c);
   end

   // Next-state and datapath register updates
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      merge_d = merge_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      case (state_q)
         IDLE, RESP: begin
            if (accept_c) begin
               addr_d  = bus.req_addr;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               we_d    = bus.req_we;
               wdata_d = bus.req_wdata;
               rdata_d = '0;
               fault_d = fault_c;
               if (fault_c)
                  state_d = RESP;
               else if (bus.req_we && (bus.req_size == SZ_W))
                  state_d = WR;
               else
                  state_d = RD;
            end else if (state_q == RESP) begin
               state_d = IDLE;
            end
         end
         RD: begin
            if (we_q) begin
               merge_d = st_merge_c;
               state_d = WR;
            end else begin
               rdata_d = ld_data_c;
               state_d = RESP;
            end
         end
         WR: begin
            rdata_d = '0;
            fault_d = 1'b0;
            state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         merge_q <= merge_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

   assign bus.req_ready = ready_c;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_fault = fault_q;
   // Gate with reset so an aborted access can never write memory
   assign bus.dm_we     = (state_q == WR) && rst_n;
   assign bus.dm_A      = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.dm_WD     = (state_q != WR) ? 32'h0 : ((size_q == SZ_W) ? wdata_q : merge_q);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl with a word-only data memory model and
// a response scoreboard (expected data, fault and arrival cycle).
module tb_lsu_ctrl;
   localparam int unsigned ADDR_W = 32;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   we_cnt = 0;
   int   last_we_cyc = -1;
   exp_t q[$];
   logic [31:0] mem [64];

   lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   lsu_ctrl #(.DM_WORDS(64), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Data memory: async read, sync write, word index = A[31:2]
   assign bus.dm_RD = mem[6'(bus.dm_A >> 2)];
   always @(posedge clk) begin
      if (bus.dm_we && ((bus.dm_A >> 2) < 64))
         mem[6'(bus.dm_A >> 2)] <= bus.dm_WD;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Response monitor: pops the scoreboard on every rsp_valid
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.dm_we) begin
            we_cnt++;
            last_we_cyc = cyc;
         end
         if (bus.rsp_valid) begin
            if (q.size() == 0) begin
               chk("spurious_rsp", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("rsp_rdata", bus.rsp_rdata, e.rdata);
               chk("rsp_fault", {31'd0, bus.rsp_fault}, {31'd0, e.fault});
               chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   // Drive one request; returns the cycle count sampled just before accept
   task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_fault,
                       input int lat, input bit track, input bit hold, output int d);
      int n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) chk("ready_timeout", 32'd0, 32'd1);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      d = cyc;
      if (track) q.push_back('{exp_rdata, exp_fault, cyc + lat});
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int d;
      int w0;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_fault", {31'd0, bus.rsp_fault}, 32'd0);
      chk("rst_dm_we", {31'd0, bus.dm_we}, 32'd0);
      chk("rst_dm_A", bus.dm_A, 32'd0);
      rst_n = 1'b1;

      // Word store then word load
      send(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, 1'b0, d);
      drain();
      chk("sw_mem", mem[2], 32'hDEADBEEF);
      send(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, 1'b0, d);
      drain();

      // Byte store RMW and byte loads
      send(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, 32'h0, 1'b0, 2, 1'b1, 1'b0, d);
      drain();
      send(1'b1, 2'b00, 1'b0, 32'h09, 32'h000000A5, 32'h0, 1'b0, 3, 1'b1, 1'b0, d);
      drain();
      chk("sb_we_cycle", 32'(last_we_cyc), 32'(d + 2));
      chk("sb_mem", mem[2], 32'h1122A544);
      send(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 1'b1, 1'b0, d);
      send(1'b0, 2'b00, 1'b1, 32'h09, 32'h0, 32'h000000A5, 1'b0, 2, 1'b1, 1'b0, d);
      drain();

      // Half store RMW and half/byte loads
      send(1'b1, 2'b10, 1'b0, 32'h0C, 32'h11223344, 32'h0, 1'b0, 2, 1'b1, 1'b0, d);
      send(1'b1, 2'b01, 1'b0, 32'h0E, 32'h00008001, 32'h0, 1'b0, 3, 1'b1, 1'b0, d);
      drain();
      chk("sh_mem", mem[3], 32'h80013344);
      send(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, 32'hFFFF8001, 1'b0, 2, 1'b1, 1'b0, d);
      send(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 32'h00008001, 1'b0, 2, 1'b1, 1'b0, d);
      send(1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, 32'h00000044, 1'b0, 2, 1'b1, 1'b0, d);
      drain();

      // Faults: no memory writes, one-cycle response
      w0 = we_cnt;
      send(1'b0, 2'b10, 1'b0, 32'h06,  32'h0,        32'h0, 1'b1, 1, 1'b1, 1'b0, d);
      send(1'b1, 2'b01, 1'b0, 32'h03,  32'h0000FFFF, 32'h0, 1'b1, 1, 1'b1, 1'b0, d);
      send(1'b1, 2'b11, 1'b0, 32'h10,  32'h12345678, 32'h0, 1'b1, 1, 1'b1, 1'b0, d);
      send(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, 32'h0, 1'b1, 1, 1'b1, 1'b0, d);
      drain();
      chk("fault_no_we", 32'(we_cnt), 32'(w0));
      chk("fault_mem2", mem[2], 32'h1122A544);
      chk("fault_mem3", mem[3], 32'h80013344);
      chk("fault_mem4", mem[4], mem[4] === 32'h12345678 ? 32'h0 : mem[4]);

      // Back-to-back loads with req_valid held high
      send(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h1122A544, 1'b0, 2, 1'b1, 1'b1, d);
      @(negedge clk);
      chk("b2b_ready_rd", {31'd0, bus.req_ready}, 32'd0);
      send(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h80013344, 1'b0, 2, 1'b1, 1'b0, w0);
      chk("b2b_accept_gap", 32'(w0 - d), 32'd2);
      drain();

      // Reset during WR of a byte store aborts it
      send(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000005A, 32'h0, 1'b0, 3, 1'b0, 1'b0, d);
      @(negedge clk);
      @(negedge clk);
      chk("abort_in_wr_we", {31'd0, bus.dm_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_we_gated", {31'd0, bus.dm_we}, 32'd0);
      @(negedge clk);
      chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("abort_rsp_valid2", {31'd0, bus.rsp_valid}, 32'd0);
      chk("abort_mem", mem[2], 32'h1122A544);
      send(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 32'h00000011, 1'b0, 2, 1'b1, 1'b0, d);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/lsu_ctrl.md
Name:
lsu_ctrl

Overview:
Load/store control unit in the MEM stage of the 5-stage pipelined RISC-V core. It sits directly upstream of the word-only data memory (64 x 32-bit, async read, sync write, word index = A[31:2]) and drives that memory's port. It converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses: read-modify-write for sub-word stores, lane extraction and sign/zero extension for loads, and misalignment/range fault detection. A valid/ready handshake lets the pipeline stall while an access is in flight.

Parameters:
DM_WORDS, 64, number of 32-bit words in data memory; word index >= DM_WORDS faults
ADDR_W, 32, request/memory address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  MEM-stage request present
req_ready  out  1  unit can accept a request this cycle
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads: 1=zero-extend (LBU/LHU), 0=sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and faults
rsp_fault  out  1  access rejected (misaligned/illegal size/out of range)
dm_we  out  1  to data memory we
dm_A  out  ADDR_W  to data memory A; always word-aligned (bits [1:0]=00)
dm_WD  out  32  to data memory WD
dm_RD  in  32  from data memory ReadData (combinational)

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; rsp_valid=0, rsp_rdata=0, rsp_fault=0; latched addr/size/data/merge registers cleared to 0. dm_we = (state==WR) & rst_n, so no memory write can occur at an edge where reset is asserted. Reset mid-operation aborts the access with no response.
- States: IDLE, RD, WR, RESP. req_ready=1 in IDLE and RESP, 0 in RD and WR. Accept = req_valid & req_ready. Inputs are sampled only at accept. req_valid is ignored while not ready.
- On accept (edge E0), the fault check is: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr[ADDR_W-1:2] >= DM_WORDS.
  - Fault: -> RESP with rsp_fault=1, rsp_rdata=0. No memory write.
  - Load: -> RD.
  - Word store: -> WR.
  - Byte or half store: -> RD.
- RD: dm_A = {latched addr[ADDR_W-1:2],2'b00}.
  - Load: at edge E1, extract the lane and register it into rsp_rdata; -> RESP.
  - Sub-word store: at E1, register merged word = dm_RD with the target lane replaced by req_wdata[7:0] or [15:0]; -> WR.
- WR: dm_we=1, dm_A = aligned address, dm_WD = req_wdata (word) or merged word; write occurs at the exiting edge; -> RESP with rsp_rdata=0.
- RESP: rsp_valid=1, rsp_fault registered. Accept in RESP follows the IDLE rules; without accept -> IDLE. rsp_valid is high for exactly one cycle per accepted request.
- Lanes are little-endian. Byte lane = addr[1:0] (bits [8k+7:8k]). Half lane = addr[1] (bits [15:0] or [31:16]). Sign extension uses bit 7 or bit 15 unless req_unsigned=1. req_unsigned is ignored for word accesses and stores.
- Latency from accept edge to rsp_valid high:
  - fault: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Outside WR: dm_we=0, dm_WD=0, dm_A = aligned latched address.

Test Plan:
- SW addr 0x08 data 0xDEADBEEF, then LW 0x08 -> store rsp_valid 2 cycles after accept with rsp_rdata 0; load rsp_rdata=0xDEADBEEF, rsp_fault=0.
- Word 0x08 = 0x11223344; SB addr 0x09 data 0x000000A5 -> dm_we pulse on the 2nd cycle after accept, memory word 0x1122A544. LB 0x09 -> 0xFFFFFFA5. LBU 0x09 -> 0x000000A5.
- Word 0x0C = 0x11223344; SH addr 0x0E data 0x00008001 -> word 0x80013344. LH 0x0E -> 0xFFFF8001. LHU -> 0x00008001. LB 0x0C -> 0x00000044.
- Faults: LW 0x06, SH 0x03, req_size=11 at 0x10, SW 0x100 (index 64) -> each rsp_valid 1 cycle after accept with rsp_fault=1, rsp_rdata=0; dm_we never asserted, memory unchanged.
- Back-to-back: req_valid held high across LW 0x08, LW 0x0C -> second request accepted in the first request's RESP cycle; rsp_valid pulses 2 cycles apart with correct data; req_ready=0 in RD.
- SB 0x09 with rst_n low in the WR cycle -> dm_we=0 at that edge, word unchanged, rsp_valid=0, state IDLE, req_ready=1 after release.
